// File: rtl/adc_dac_spi_bridge_pkg.sv
// Shared definitions for the ADC-FIFO to SPI-DAC bridge: FSM states,
// SPI master register map and command-word packing.
package adc_dac_spi_bridge_pkg;

  localparam int unsigned ADR_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 34;

  typedef enum logic [3:0] {
    INIT_DIV  = 4'd0,
    INIT_CTRL = 4'd1,
    IDLE      = 4'd2,
    POP       = 4'd3,
    LATCH     = 4'd4,
    WR_TX     = 4'd5,
    WR_SS     = 4'd6,
    WR_GO     = 4'd7,
    WAIT_INT  = 4'd8
  } state_t;

  localparam logic [ADR_W-1:0] ADR_TX0  = 8'h00;
  localparam logic [ADR_W-1:0] ADR_CTRL = 8'h10;
  localparam logic [ADR_W-1:0] ADR_DIV  = 8'h14;
  localparam logic [ADR_W-1:0] ADR_SS   = 8'h18;

  localparam int unsigned CTRL_GO_BIT = 8;
  localparam logic [1:0]  CMD_WR      = 2'b01;

  // Register-write command word as seen by the SPI master command port.
  function automatic logic [CMD_W-1:0] cmd_pack(input logic [DATA_W-1:0] data);
    return {CMD_WR, data};
  endfunction

endpackage

// File: rtl/adc_dac_spi_bridge_adc_to_dac_code.sv
// ADC sample to DAC code conversion (combinational).
// Ports: sample_i - raw ADC sample; code_c - DAC code (top DAC_W bits,
// MSB inverted for two's-complement input to give offset binary).
module adc_dac_spi_bridge_adc_to_dac_code
  import adc_dac_spi_bridge_pkg::*;
#(
  parameter int unsigned ADC_W     = 16,
  parameter int unsigned DAC_W     = 14,
  parameter bit          SIGNED_IN = 1'b1
) (
  input  logic [ADC_W-1:0] sample_i,
  output logic [DAC_W-1:0] code_c
);

  localparam logic [DAC_W-1:0] MSB_MASK =
    SIGNED_IN ? (DAC_W'(1) << (DAC_W - 1)) : '0;

  // LSBs below DAC resolution are intentionally dropped.
  logic unused_c;
  assign unused_c = ^sample_i;

  assign code_c = sample_i[ADC_W-1 -: DAC_W] ^ MSB_MASK;

endmodule

// File: rtl/adc_dac_spi_bridge.sv
// Multi-channel ADC FIFO to SPI DAC forwarder.
// Initialises the SPI master (DIVIDE, CTRL), then services N_CH FIFOs
// round-robin: pop, convert, write TX0 / SS / CTRL+GO, wait for int_o.
// Ports: clk, rst (sync, active-high), en, empty/adc_dat_i (FIFO side),
// rd_en (pop), adr/cmd_word/cmd_stb/cmd_ack (register command port),
// int_o (transfer done), busy, cur_ch. All outputs registered.
module adc_dac_spi_bridge
  import adc_dac_spi_bridge_pkg::*;
#(
  parameter int unsigned ADC_W     = 16,
  parameter int unsigned DAC_W     = 14,
  parameter int unsigned N_CH      = 2,
  parameter bit          SIGNED_IN = 1'b1,
  parameter logic [31:0] DIVIDER   = 32'h0,
  parameter logic [31:0] CTRL_BASE = 32'h0000_3010,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_CH-1:0]       empty,
  input  logic [N_CH*ADC_W-1:0] adc_dat_i,
  output logic [N_CH-1:0]       rd_en,
  output logic [ADR_W-1:0]      adr,
  output logic [CMD_W-1:0]      cmd_word,
  output logic                  cmd_stb,
  input  logic                  cmd_ack,
  input  logic                  int_o,
  output logic                  busy,
  output logic [CH_W-1:0]       cur_ch
);

  localparam logic [DATA_W-1:0] CTRL_GO = CTRL_BASE | (DATA_W'(1) << CTRL_GO_BIT);

  state_t            state_q, state_d;
  logic [N_CH-1:0]   rd_en_q, rd_en_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [CMD_W-1:0]  cmd_word_q, cmd_word_d;
  logic              cmd_stb_q, cmd_stb_d;
  logic              busy_q, busy_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;

  logic [ADC_W-1:0]  sample_c;
  logic [DAC_W-1:0]  code_c;
  logic              ch_empty_c;
  logic [CH_W-1:0]   next_ch_c;
  logic              accepted_c;

  adc_dac_spi_bridge_adc_to_dac_code #(
    .ADC_W    (ADC_W),
    .DAC_W    (DAC_W),
    .SIGNED_IN(SIGNED_IN)
  ) u_conv (
    .sample_i(sample_c),
    .code_c  (code_c)
  );

  // Current-channel views of the FIFO side and round-robin successor.
  always_comb begin
    sample_c   = '0;
    ch_empty_c = 1'b1;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (cur_ch_q == CH_W'(c)) begin
        sample_c   = adc_dat_i[c*ADC_W +: ADC_W];
        ch_empty_c = empty[c];
      end
    end
    next_ch_c = (cur_ch_q == CH_W'(N_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    rd_en_d    = '0;
    adr_d      = adr_q;
    cmd_word_d = cmd_word_q;
    cmd_stb_d  = cmd_stb_q;
    cur_ch_d   = cur_ch_q;
    accepted_c = cmd_stb_q && cmd_ack;

    // A completed handshake always returns the command port to idle.
    if (accepted_c) begin
      cmd_stb_d  = 1'b0;
      adr_d      = '0;
      cmd_word_d = '0;
    end

    case (state_q)
      INIT_DIV: begin
        if (!cmd_stb_q) begin
          cmd_stb_d  = 1'b1;
          adr_d      = ADR_DIV;
          cmd_word_d = cmd_pack(DIVIDER);
        end else if (accepted_c) begin
          state_d = INIT_CTRL;
        end
      end
      INIT_CTRL: begin
        if (!cmd_stb_q) begin
          cmd_stb_d  = 1'b1;
          adr_d      = ADR_CTRL;
          cmd_word_d = cmd_pack(CTRL_BASE);
        end else if (accepted_c) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (en) begin
          if (!ch_empty_c) begin
            state_d = POP;
            rd_en_d = N_CH'(1) << cur_ch_q;
          end else begin
            cur_ch_d = next_ch_c;
          end
        end
      end
      POP: state_d = LATCH;
      // FIFO data is valid now; the TX command is issued straight from it.
      LATCH: begin
        cmd_stb_d  = 1'b1;
        adr_d      = ADR_TX0;
        cmd_word_d = cmd_pack(DATA_W'(code_c));
        state_d    = WR_TX;
      end
      WR_TX: begin
        if (accepted_c) state_d = WR_SS;
      end
      WR_SS: begin
        if (!cmd_stb_q) begin
          cmd_stb_d  = 1'b1;
          adr_d      = ADR_SS;
          cmd_word_d = cmd_pack(DATA_W'(1) << cur_ch_q);
        end else if (accepted_c) begin
          state_d = WR_GO;
        end
      end
      WR_GO: begin
        if (!cmd_stb_q) begin
          cmd_stb_d  = 1'b1;
          adr_d      = ADR_CTRL;
          cmd_word_d = cmd_pack(CTRL_GO);
        end else if (accepted_c) begin
          state_d = WAIT_INT;
        end
      end
      WAIT_INT: begin
        if (int_o) begin
          cur_ch_d = next_ch_c;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d    = INIT_DIV;
        cmd_stb_d  = 1'b0;
        adr_d      = '0;
        cmd_word_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_DIV;
      rd_en_q    <= '0;
      adr_q      <= '0;
      cmd_word_q <= '0;
      cmd_stb_q  <= 1'b0;
      busy_q     <= 1'b1;
      cur_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      adr_q      <= adr_d;
      cmd_word_q <= cmd_word_d;
      cmd_stb_q  <= cmd_stb_d;
      busy_q     <= busy_d;
      cur_ch_q   <= cur_ch_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign adr      = adr_q;
  assign cmd_word = cmd_word_q;
  assign cmd_stb  = cmd_stb_q;
  assign busy     = busy_q;
  assign cur_ch   = cur_ch_q;

endmodule

// File: tb/tb_adc_dac_spi_bridge.sv
// Directed testbench for adc_dac_spi_bridge (default parameters).
// Environment process models the FIFOs, the SPI master command ack
// (2-cycle latency, optionally withheld) and the transfer-done interrupt.
module tb_adc_dac_spi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [1:0]  empty;
  logic [31:0] adc_dat;
  logic [1:0]  rd_en;
  logic [7:0]  adr;
  logic [33:0] cmd_word;
  logic        cmd_stb;
  logic        cmd_ack;
  logic        int_o;
  logic        busy;
  logic [0:0]  cur_ch;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] fq0[$];
  logic [15:0] fq1[$];
  logic [41:0] log_q[$];
  int          rd_cnt0 = 0;
  int          rd_cnt1 = 0;
  bit          ack_hold = 1'b0;
  int          int_delay = 10;
  int          stb_cnt = 0;
  int          int_cnt = 0;

  adc_dac_spi_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .empty    (empty),
    .adc_dat_i(adc_dat),
    .rd_en    (rd_en),
    .adr      (adr),
    .cmd_word (cmd_word),
    .cmd_stb  (cmd_stb),
    .cmd_ack  (cmd_ack),
    .int_o    (int_o),
    .busy     (busy),
    .cur_ch   (cur_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] get_log(input int idx);
    if (idx < log_q.size()) return log_q[idx];
    return '1;
  endfunction

  task automatic chk_log(input string tag, input int idx, input logic [7:0] a, input logic [33:0] w);
    chk(tag, 64'(get_log(idx)), 64'({a, w}));
  endtask

  task automatic wait_busy(input logic val, input int max, input string tag);
    int i = 0;
    while (busy !== val && i < max) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(busy), 64'(val));
  endtask

  task automatic wait_log(input int n, input int max, input string tag);
    int i = 0;
    while (log_q.size() < n && i < max) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(log_q.size() >= n), 64'd1);
  endtask

  // Environment: ack model, interrupt model and FIFO model, all on negedge.
  initial begin
    empty   = 2'b11;
    adc_dat = '0;
    cmd_ack = 1'b0;
    int_o   = 1'b0;
    forever begin
      @(negedge clk);
      int_o = 1'b0;
      if (int_cnt > 0) begin
        int_cnt--;
        if (int_cnt == 0) int_o = 1'b1;
      end
      if (cmd_stb && !ack_hold && !rst) begin
        stb_cnt++;
        cmd_ack = (stb_cnt >= 2);
        if (cmd_ack) begin
          log_q.push_back({adr, cmd_word});
          if (adr == 8'h10 && cmd_word[8]) int_cnt = int_delay;
        end
      end else begin
        stb_cnt = 0;
        cmd_ack = 1'b0;
      end
      if (rd_en[0]) begin
        if (fq0.size() > 0) adc_dat[15:0] = fq0.pop_front();
        rd_cnt0++;
      end
      if (rd_en[1]) begin
        if (fq1.size() > 0) adc_dat[31:16] = fq1.pop_front();
        rd_cnt1++;
      end
      empty = {fq1.size() == 0, fq0.size() == 0};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int i;
    // Reset values
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_adr", 64'(adr), 64'h00);
    chk("rst_cmd_word", 64'(cmd_word), 64'h0);
    chk("rst_cmd_stb", 64'(cmd_stb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_cur_ch", 64'(cur_ch), 64'd0);

    // Init sequence
    rst = 1'b0;
    wait_busy(1'b0, 40, "init_done");
    chk("init_ncmd", 64'(log_q.size()), 64'd2);
    chk_log("init_div", 0, 8'h14, 34'h1_0000_0000);
    chk_log("init_ctrl", 1, 8'h10, 34'h1_0000_3010);
    chk("init_no_pop", 64'(rd_cnt0 + rd_cnt1), 64'd0);

    // Single sample on ch0
    log_q.delete();
    en = 1'b1;
    fq0.push_back(16'h7FFC);
    wait_busy(1'b1, 20, "s1_start");
    wait_busy(1'b0, 100, "s1_done");
    en = 1'b0;
    chk("s1_ncmd", 64'(log_q.size()), 64'd3);
    chk_log("s1_tx", 0, 8'h00, 34'h1_0000_3FFF);
    chk_log("s1_ss", 1, 8'h18, 34'h1_0000_0001);
    chk_log("s1_go", 2, 8'h10, 34'h1_0000_3110);
    chk("s1_rd0", 64'(rd_cnt0), 64'd1);
    chk("s1_rd1", 64'(rd_cnt1), 64'd0);
    chk("s1_cur_ch_adv", 64'(cur_ch), 64'd1);

    // en=0 with data present: nothing happens
    log_q.delete();
    rd_cnt0 = 0;
    rd_cnt1 = 0;
    fq0.push_back(16'h8000);
    fq1.push_back(16'h0000);
    repeat (20) @(negedge clk);
    chk("en0_no_pop", 64'(rd_cnt0 + rd_cnt1), 64'd0);
    chk("en0_no_cmd", 64'(log_q.size()), 64'd0);
    chk("en0_busy", 64'(busy), 64'd0);
    chk("en0_cur_ch", 64'(cur_ch), 64'd1);

    // Raise en: ch1 serviced first, then ch0
    en = 1'b1;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (rd_en == 2'b00 && i < 3);
    chk("en1_first_pop", 64'(rd_en), 64'h2);
    wait_log(6, 200, "rr_cmds");
    wait_busy(1'b0, 100, "rr_done");
    chk_log("rr_tx1", 0, 8'h00, 34'h1_0000_2000);
    chk_log("rr_ss1", 1, 8'h18, 34'h1_0000_0002);
    chk_log("rr_go1", 2, 8'h10, 34'h1_0000_3110);
    chk_log("rr_tx0", 3, 8'h00, 34'h1_0000_0000);
    chk_log("rr_ss0", 4, 8'h18, 34'h1_0000_0001);
    chk_log("rr_go0", 5, 8'h10, 34'h1_0000_3110);
    chk("rr_rd0", 64'(rd_cnt0), 64'd1);
    chk("rr_rd1", 64'(rd_cnt1), 64'd1);

    // Withheld ack: command held stable, no further pops
    log_q.delete();
    rd_cnt0 = 0;
    ack_hold = 1'b1;
    fq0.push_back(16'h7FFC);
    i = 0;
    while (cmd_stb !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("hold_stb_up", 64'(cmd_stb), 64'd1);
    repeat (20) begin
      @(negedge clk);
      chk("hold_stb", 64'(cmd_stb), 64'd1);
      chk("hold_adr", 64'(adr), 64'h00);
      chk("hold_word", 64'(cmd_word), 64'h1_0000_3FFF);
      chk("hold_rd_en", 64'(rd_en), 64'd0);
    end
    ack_hold = 1'b0;
    wait_log(3, 100, "hold_cmds");
    wait_busy(1'b0, 100, "hold_done");
    chk_log("hold_tx", 0, 8'h00, 34'h1_0000_3FFF);
    chk_log("hold_ss", 1, 8'h18, 34'h1_0000_0001);
    chk_log("hold_go", 2, 8'h10, 34'h1_0000_3110);
    chk("hold_rd0", 64'(rd_cnt0), 64'd1);

    // Reset during WR_SS aborts and re-runs init
    log_q.delete();
    fq0.push_back(16'h8000);
    i = 0;
    while (!(cmd_stb === 1'b1 && adr === 8'h18) && i < 60) begin
      @(negedge clk);
      i++;
    end
    chk("mrst_in_ss", 64'(adr), 64'h18);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_stb", 64'(cmd_stb), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd1);
    chk("mrst_cur_ch", 64'(cur_ch), 64'd0);
    chk("mrst_word", 64'(cmd_word), 64'h0);
    log_q.delete();
    rst = 1'b0;
    wait_busy(1'b0, 40, "mrst_init_done");
    chk("mrst_ncmd", 64'(log_q.size()), 64'd2);
    chk_log("mrst_div", 0, 8'h14, 34'h1_0000_0000);
    chk_log("mrst_ctrl", 1, 8'h10, 34'h1_0000_3010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_dac_spi_bridge.md
# adc_dac_spi_bridge

Multi-channel successor to the single-channel ADC-FIFO-to-DAC forwarder. It initialises the SPI master over its register command port, then services N_CH ADC sample FIFOs round-robin. Each sample is converted to DAC code and sent through three register writes: TX0 data, SS one-hot channel select, and CTRL with GO. It then waits for the SPI master's completion interrupt. The block sits between the AD796x capture FIFOs and the SPI master that drives the AD5453-class DACs.

## Interface
- ADC_W, 16, ADC sample width
- DAC_W, 14, DAC code width; ≤ ADC_W
- N_CH, 2, channel count, 1..8
- SIGNED_IN, 1, 1 = two's-complement input (MSB inverted on conversion); 0 = offset-binary passthrough
- DIVIDER, 32'h0, value written to DIVIDE (adr 8'h14)
- CTRL_BASE, 32'h0000_3010, CTRL value without GO (adr 8'h10); GO is bit 8

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high
- en  in  1  service enable; 0 parks in IDLE after the current sample
- empty  in  N_CH  per-channel FIFO empty
- adc_dat_i  in  N_CH*ADC_W  per-channel FIFO data, channel c at [c*ADC_W +: ADC_W]; valid the cycle after rd_en
- rd_en  out  N_CH  one-cycle pop pulse, at most one bit set
- adr  out  8  SPI master register address
- cmd_word  out  34  {2'b01, 32-bit data}; 34'h0 when idle
- cmd_stb  out  1  command request, held until acked
- cmd_ack  in  1  command accepted
- int_o  in  1  SPI master transfer-complete interrupt (level)
- busy  out  1  high in any state other than IDLE
- cur_ch  out  $clog2(N_CH) (min 1)  channel being serviced

## Operation
- States: INIT_DIV → INIT_CTRL → IDLE → POP → LATCH → WR_TX → WR_SS → WR_GO → WAIT_INT → IDLE.
- INIT_DIV issues adr 8'h14 with DIVIDER. INIT_CTRL issues adr 8'h10 with CTRL_BASE. Each state advances on its ack.
- IDLE, with en=1:
  - if empty[cur_ch]=0, go to POP;
  - otherwise advance cur_ch (wraps N_CH-1 → 0) and stay.
  - With en=0, hold cur_ch and stay.
- POP: rd_en[cur_ch]=1 for one cycle.
- LATCH: capture code = adc_dat_i[cur_ch][ADC_W-1 -: DAC_W]. If SIGNED_IN=1, invert the code MSB; this equals ±2^(DAC_W-1) modulo 2^DAC_W. Examples (DAC_W=14): 16'h8000 → 14'h0000; 16'h7FFC → 14'h3FFF; 16'h0000 → 14'h2000.
- WR_TX: adr 8'h00, data = zero-extended code.
- WR_SS: adr 8'h18, data = 1<<cur_ch.
- WR_GO: adr 8'h10, data = CTRL_BASE | 32'h100.
- WAIT_INT: exit when int_o=1. cur_ch then advances (round-robin fairness), and the state returns to IDLE.
- Unused/illegal state encodings recover to INIT_DIV.

## Timing
- Reset values: rd_en=0, adr=8'h00, cmd_word=34'h0, cmd_stb=0, busy=1, cur_ch=0, state INIT_DIV.
- rst mid-operation aborts immediately, drops cmd_stb, and repeats init. Any unread popped sample is lost.
- All outputs are registered.
- Command handshake:
  - cmd_stb rises with adr/cmd_word stable; both stay stable until the cycle where cmd_stb && cmd_ack.
  - cmd_stb is low the following cycle, so there is at least one idle cycle between commands.
  - cmd_ack while cmd_stb=0 is ignored.
- Latency: IDLE seeing !empty at cycle t → rd_en at t+1 → code latched at t+2 → cmd_stb for TX at t+3.
- int_o is sampled only in WAIT_INT. A stale int_o high during earlier states has no effect.
- Simultaneous events: en falling in WAIT_INT still completes the sample. empty rising during POP is ignored, since the pop was already committed on !empty.

## Structure
- Shared package: state enum; register addresses ADR_TX0=8'h00, ADR_CTRL=8'h10, ADR_DIV=8'h14, ADR_SS=8'h18; CTRL_GO_BIT=8; CMD_WR=2'b01.
- One sub-module, adc_to_dac_code: combinational width truncation plus MSB inversion, parametrised by ADC_W, DAC_W, SIGNED_IN.

## Test plan
- Reset release with the ack model acking after 2 cycles → exactly two commands, (8'h14, 34'h1_0000_0000) then (8'h10, 34'h1_0000_3010), then IDLE with busy=0.
- Ch0 holds 16'h7FFC, int_o pulses 10 cycles after GO → commands (00, 1_0000_3FFF), (18, 1_0000_0001), (10, 1_0000_3110); one rd_en[0] pulse.
- Both channels non-empty with samples 16'h8000 and 16'h0000 → alternating ch0/ch1 service, TX codes 0000/2000, SS data 1/2.
- cmd_ack withheld for 20 cycles → cmd_stb, adr, cmd_word stable throughout; no rd_en.
- en=0 with data present → no rd_en or commands. Raise en → service begins within 3 cycles.
- rst asserted during WR_SS → cmd_stb=0 the next cycle, then the init sequence is reissued.
